// File: rtl/mem_read_master_pkg.sv
// Shared definitions for the memory read master: FSM encoding and
// default geometry of the memory slave.
`default_nettype none

package mem_read_master_pkg;

  localparam int ADDR_W_DEFAULT = 10;
  localparam int DATA_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO with occupancy count.
// The head word is visible on rd_data whenever valid is high.
`default_nettype none

module sync_fifo_fwft #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_wr;
  logic             do_rd;

  assign valid = (count != '0);
  assign full  = (count == CW'(DEPTH));
  // A write into a full buffer is only legal when the head leaves in the same cycle.
  assign do_wr = wr_en && (!full || rd_en);
  assign do_rd = rd_en && valid;
  assign rd_data = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      if (do_wr && !do_rd)      count <= count + CW'(1);
      else if (!do_wr && do_rd) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

`default_nettype wire

// File: rtl/mem_read_master.sv
// Reads a block of words from a fixed-latency memory slave and streams them
// out through a FWFT buffer, issuing requests only when buffer space is reserved.
`default_nettype none

module mem_read_master
  import mem_read_master_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEFAULT,
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     word_count,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_chipselect,
  output logic                avm_write,
  output logic [DATA_W/8-1:0] avm_byteenable,
  input  logic [DATA_W-1:0]   avm_readdata,
  output logic [DATA_W-1:0]   st_data,
  output logic                st_valid,
  input  logic                st_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   remaining;
  logic              inflight;
  logic              zero_done;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       occupancy;
  logic              req;
  logic              last_pop;

  // Reserve a buffer slot for the beat still on its way back from the slave.
  assign occupancy = {1'b0, fifo_count} + (CW+1)'(inflight);
  assign req       = (state == RUN) && (remaining != '0) &&
                     (occupancy < (CW+1)'(FIFO_DEPTH));
  assign last_pop  = (state == DRAIN) && !inflight && (fifo_count == CW'(1)) &&
                     st_valid && st_ready;

  assign avm_address    = addr;
  assign avm_write      = 1'b0;
  assign avm_byteenable = '1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      inflight  <= 1'b0;
      zero_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      inflight  <= req;
      zero_done <= (state == IDLE) && start && (word_count == '0);
      if ((state == IDLE) && start) begin
        addr      <= base_addr;
        remaining <= word_count;
      end else if (req) begin
        addr      <= addr + ADDR_W'(1);
        remaining <= remaining - (ADDR_W+1)'(1);
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    busy           = (state != IDLE);
    done           = zero_done || last_pop;
    avm_chipselect = req;
    case (state)
      IDLE:    if (start && (word_count != '0)) state_nxt = RUN;
      RUN:     if (req && (remaining == (ADDR_W+1)'(1))) state_nxt = DRAIN;
      DRAIN:   if (last_pop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  sync_fifo_fwft #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .wr_en   (inflight),
    .wr_data (avm_readdata),
    .rd_en   (st_ready),
    .rd_data (st_data),
    .valid   (st_valid),
    .count   (fifo_count)
  );

endmodule

`default_nettype wire

// File: tb/tb_mem_read_master.sv
// Self-checking bench for mem_read_master: table of transfers plus hand-written
// reset-abort sequence, with address/data scoreboards fed at start time.
`default_nettype none

module tb_mem_read_master;

  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            start;
  logic [AW-1:0]   base_addr;
  logic [AW:0]     word_count;
  logic            busy;
  logic            done;
  logic [AW-1:0]   avm_address;
  logic            avm_chipselect;
  logic            avm_write;
  logic [DW/8-1:0] avm_byteenable;
  logic [DW-1:0]   avm_readdata;
  logic [DW-1:0]   st_data;
  logic            st_valid;
  logic            st_ready;

  always #5 clk = ~clk;

  mem_read_master #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .base_addr      (base_addr),
    .word_count     (word_count),
    .busy           (busy),
    .done           (done),
    .avm_address    (avm_address),
    .avm_chipselect (avm_chipselect),
    .avm_write      (avm_write),
    .avm_byteenable (avm_byteenable),
    .avm_readdata   (avm_readdata),
    .st_data        (st_data),
    .st_valid       (st_valid),
    .st_ready       (st_ready)
  );

  // Memory slave model: data one cycle after the request, junk otherwise.
  logic [DW-1:0] mem [1<<AW];
  always @(posedge clk)
    avm_readdata <= avm_chipselect ? mem[avm_address] : 32'hDEAD_BEEF;

  int n_checks = 0;
  int n_pass   = 0;
  int cs_cycles, busy_cycles, done_pulses, words_seen, max_fifo;
  int first_valid_k, cur_k;
  logic [DW-1:0] exp_data [$];
  logic [AW-1:0] exp_addr [$];
  logic          stall_prev = 1'b0;
  logic [DW-1:0] data_prev;
  bit            toggle_mode = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic clear_counters();
    cs_cycles = 0; busy_cycles = 0; done_pulses = 0; words_seen = 0;
    max_fifo = 0; first_valid_k = -1;
  endtask

  task automatic push_expected(input int base, input int count);
    logic [AW-1:0] a;
    for (int n = 0; n < count; n++) begin
      a = AW'(base + n);
      exp_addr.push_back(a);
      exp_data.push_back(mem[a]);
    end
  endtask

  // Monitor: scoreboards, stall stability and activity counters.
  always @(negedge clk) begin
    if (reset_n) begin
      if (avm_chipselect) begin
        cs_cycles++;
        if (exp_addr.size() != 0) check("req_addr", 64'(avm_address), 64'(exp_addr.pop_front()));
        else check("req_queue_nonempty", 64'(exp_addr.size()), 64'd1);
      end
      if (st_valid && first_valid_k < 0) first_valid_k = cur_k;
      if (stall_prev) check("stall_stable", 64'(st_data), 64'(data_prev));
      if (st_valid && st_ready) begin
        words_seen++;
        if (exp_data.size() != 0) check("st_data", 64'(st_data), 64'(exp_data.pop_front()));
        else check("word_queue_nonempty", 64'(exp_data.size()), 64'd1);
      end
      stall_prev = st_valid && !st_ready;
      data_prev  = st_data;
      if (busy) busy_cycles++;
      if (done) done_pulses++;
      if (int'(dut.u_fifo.count) > max_fifo) max_fifo = int'(dut.u_fifo.count);
    end else begin
      stall_prev = 1'b0;
    end
  end

  // Sink ready driver: constant 1 or the repeating 1,0,0,1 pattern.
  initial begin
    bit [3:0] pat = 4'b1001;
    int ph = 0;
    st_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (toggle_mode) begin
        st_ready = pat[ph];
        ph = (ph + 1) % 4;
      end else begin
        st_ready = 1'b1;
        ph = 0;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, " busy"},      64'(busy), 64'd0);
    check({tag, " done"},      64'(done), 64'd0);
    check({tag, " cs"},        64'(avm_chipselect), 64'd0);
    check({tag, " addr"},      64'(avm_address), 64'd0);
    check({tag, " st_valid"},  64'(st_valid), 64'd0);
    check({tag, " st_data"},   64'(st_data), 64'd0);
  endtask

  task automatic run_transfer(input string tag, input int base, input int count,
                              input bit toggle, input int glitch,
                              input int exp_done_k, input int exp_busy);
    bit got_done = 1'b0;
    int done_k = -1;
    int budget = count * 4 + 20;
    clear_counters();
    push_expected(base, count);
    @(posedge clk); #1;
    cur_k       = 0;
    toggle_mode = toggle;
    start       = 1'b1;
    base_addr   = AW'(base);
    word_count  = (AW+1)'(count);
    @(negedge clk);
    for (int k = 1; k <= budget && !got_done; k++) begin
      @(posedge clk); #1;
      cur_k = k;
      if (k == glitch) begin
        start = 1'b1; base_addr = AW'(500); word_count = (AW+1)'(3);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done) begin got_done = 1'b1; done_k = k; end
    end
    @(posedge clk); #1;
    start = 1'b0;
    toggle_mode = 1'b0;
    repeat (3) @(negedge clk);
    check({tag, " done_seen"},    64'(got_done), 64'd1);
    check({tag, " done_pulses"},  64'(done_pulses), 64'd1);
    check({tag, " cs_cycles"},    64'(cs_cycles), 64'(count));
    check({tag, " words"},        64'(words_seen), 64'(count));
    check({tag, " addr_q_left"},  64'(exp_addr.size()), 64'd0);
    check({tag, " data_q_left"},  64'(exp_data.size()), 64'd0);
    check({tag, " fifo_le_depth"}, 64'(max_fifo <= DEPTH), 64'd1);
    if (exp_done_k >= 0) check({tag, " done_cycle"}, 64'(done_k), 64'(exp_done_k));
    if (exp_busy >= 0)   check({tag, " busy_cycles"}, 64'(busy_cycles), 64'(exp_busy));
    if (count > 0)       check({tag, " first_valid"}, 64'(first_valid_k), 64'd3);
    exp_addr.delete();
    exp_data.delete();
  endtask

  typedef struct {
    string name;
    int    base;
    int    count;
    bit    toggle;
    int    glitch;
    int    exp_done_k;
    int    exp_busy;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [7];
    bit   reached;
    vecs[0] = '{"seq8",      0,    8,    1'b0, -1, 10,   10};
    vecs[1] = '{"wrap8",     1020, 8,    1'b0, -1, 10,   10};
    vecs[2] = '{"toggle16",  300,  16,   1'b1, -1, -1,   -1};
    vecs[3] = '{"zero",      5,    0,    1'b0, -1, 1,    0};
    vecs[4] = '{"restart",   200,  12,   1'b0, 4,  14,   14};
    vecs[5] = '{"full1024",  0,    1024, 1'b0, -1, 1026, 1026};
    vecs[6] = '{"wrap2_tog", 1023, 2,    1'b1, -1, -1,   -1};

    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i);
    reset_n = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
    cur_k = 0;
    clear_counters();
    repeat (2) @(posedge clk); #1;
    check_reset_outputs("por");
    check("por byteenable", 64'(avm_byteenable), 64'hF);
    check("por write",      64'(avm_write), 64'd0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    foreach (vecs[i])
      run_transfer(vecs[i].name, vecs[i].base, vecs[i].count, vecs[i].toggle,
                   vecs[i].glitch, vecs[i].exp_done_k, vecs[i].exp_busy);

    // Abort a 20-word transfer after 5 words, then prove the block recovers.
    clear_counters();
    push_expected(100, 20);
    @(posedge clk); #1;
    start = 1'b1; base_addr = AW'(100); word_count = (AW+1)'(20);
    reached = 1'b0;
    for (int k = 0; k < 40 && !reached; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      if (words_seen >= 5) reached = 1'b1;
    end
    check("abort words_reached", 64'(reached), 64'd1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    exp_addr.delete();
    exp_data.delete();
    clear_counters();
    repeat (2) @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check("abort no_done",     64'(done_pulses), 64'd0);
    check("abort no_requests", 64'(cs_cycles), 64'd0);
    check("abort no_words",    64'(words_seen), 64'd0);
    check("abort st_valid",    64'(st_valid), 64'd0);
    run_transfer("post_abort3", 7, 3, 1'b0, -1, 5, 5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
